// File: rtl/bp_be_stride_detector.sv
// rtl/bp_be_stride_detector.sv - per-PC constant-stride learner feeding the prefetch generator
// Fully-associative table with round-robin allocation and a single-entry request buffer.
module bp_be_stride_detector #(
  parameter int vaddr_width_p  = 39,
  parameter int entries_p      = 4,
  parameter int stride_width_p = 8,
  parameter int loop_range_p   = 8,
  parameter int conf_thresh_p  = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      clear_i,
  input  logic                      commit_v_i,
  input  logic [vaddr_width_p-1:0]  commit_pc_i,
  input  logic [vaddr_width_p-1:0]  commit_eff_addr_i,
  input  logic [loop_range_p-1:0]   loop_count_i,
  output logic                      v_o,
  input  logic                      ready_and_i,
  output logic [vaddr_width_p-1:0]  pc_o,
  output logic [vaddr_width_p-1:0]  eff_addr_o,
  output logic [stride_width_p-1:0] stride_o,
  output logic [loop_range_p-1:0]   loop_counter_o
);

  localparam int idx_w = $clog2(entries_p);

  logic [entries_p-1:0]      valid_r;
  logic [entries_p-1:0]      issued_r;
  logic [vaddr_width_p-1:0]  tag_r    [entries_p];
  logic [vaddr_width_p-1:0]  last_r   [entries_p];
  logic [stride_width_p-1:0] stride_r [entries_p];
  logic [1:0]                conf_r   [entries_p];
  logic [idx_w-1:0]          ptr_r;

  logic                      buf_v_r;
  logic [vaddr_width_p-1:0]  buf_pc_r;
  logic [vaddr_width_p-1:0]  buf_addr_r;
  logic [stride_width_p-1:0] buf_stride_r;
  logic [loop_range_p-1:0]   buf_lc_r;

  logic                      hit;
  logic [idx_w-1:0]          hit_idx;
  logic [vaddr_width_p-1:0]  delta;
  logic [stride_width_p-1:0] delta_lo;
  logic                      in_range;
  logic                      match;
  logic [1:0]                hit_conf;
  logic [stride_width_p-1:0] hit_stride;
  logic                      hit_issued;
  logic [1:0]                new_conf;
  logic [stride_width_p-1:0] new_stride;
  logic                      stride_pos;
  logic                      trigger;
  logic                      accept;
  logic                      load;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < entries_p; i++) begin
      if (valid_r[i] && (tag_r[i] == commit_pc_i)) begin
        hit     = 1'b1;
        hit_idx = idx_w'(i);
      end
    end
  end

  assign hit_conf   = conf_r[hit_idx];
  assign hit_stride = stride_r[hit_idx];
  assign hit_issued = issued_r[hit_idx];

  // delta fits the stride field only if sign-extending its low bits reproduces it
  assign delta    = commit_eff_addr_i - last_r[hit_idx];
  assign delta_lo = delta[stride_width_p-1:0];
  assign in_range = (delta == {{(vaddr_width_p-stride_width_p){delta_lo[stride_width_p-1]}}, delta_lo});
  assign match    = in_range && (delta_lo == hit_stride) && (|delta);

  assign new_conf   = match ? ((hit_conf == 2'd3) ? 2'd3 : hit_conf + 2'd1) : 2'd0;
  assign new_stride = match ? hit_stride : (in_range ? delta_lo : '0);
  assign stride_pos = !new_stride[stride_width_p-1] && (|new_stride);

  assign trigger = commit_v_i && hit && (new_conf >= 2'(conf_thresh_p)) && !hit_issued
                   && stride_pos && (|loop_count_i);
  assign accept  = !buf_v_r || ready_and_i;
  assign load    = trigger && accept;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_i) begin
      valid_r      <= '0;
      issued_r     <= '0;
      ptr_r        <= '0;
      buf_v_r      <= 1'b0;
      buf_pc_r     <= '0;
      buf_addr_r   <= '0;
      buf_stride_r <= '0;
      buf_lc_r     <= '0;
    end else begin
      if (buf_v_r && ready_and_i) begin
        buf_v_r <= 1'b0;
      end
      if (load) begin
        buf_v_r      <= 1'b1;
        buf_pc_r     <= commit_pc_i;
        buf_addr_r   <= commit_eff_addr_i;
        buf_stride_r <= new_stride;
        buf_lc_r     <= loop_count_i;
      end
      if (commit_v_i) begin
        if (hit) begin
          last_r[hit_idx]   <= commit_eff_addr_i;
          stride_r[hit_idx] <= new_stride;
          conf_r[hit_idx]   <= new_conf;
          issued_r[hit_idx] <= load || (match && hit_issued);
        end else begin
          valid_r[ptr_r]  <= 1'b1;
          issued_r[ptr_r] <= 1'b0;
          tag_r[ptr_r]    <= commit_pc_i;
          last_r[ptr_r]   <= commit_eff_addr_i;
          stride_r[ptr_r] <= '0;
          conf_r[ptr_r]   <= 2'd0;
          ptr_r           <= ptr_r + idx_w'(1);
        end
      end
    end
  end

  assign v_o            = buf_v_r;
  assign pc_o           = buf_pc_r;
  assign eff_addr_o     = buf_addr_r;
  assign stride_o       = buf_stride_r;
  assign loop_counter_o = buf_lc_r;

endmodule

// File: tb/tb_bp_be_stride_detector.sv
// tb/tb_bp_be_stride_detector.sv - vectors, corner sequences and random traffic vs a reference model
module tb_bp_be_stride_detector;
  localparam int VW = 39;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n, clear, commit_v, ready;
  logic [VW-1:0] pc, addr;
  logic [7:0]    lc;
  logic          v;
  logic [VW-1:0] pco, ea;
  logic [7:0]    st, lco;

  int total = 0;
  int bad   = 0;

  bp_be_stride_detector dut (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .commit_v_i(commit_v),
    .commit_pc_i(pc), .commit_eff_addr_i(addr), .loop_count_i(lc), .v_o(v),
    .ready_and_i(ready), .pc_o(pco), .eff_addr_o(ea), .stride_o(st), .loop_counter_o(lco)
  );

  // reference model: strides kept as plain signed integers
  bit            m_v[4];
  logic [VW-1:0] m_pc[4];
  logic [VW-1:0] m_last[4];
  int            m_stride[4];
  int            m_conf[4];
  bit            m_iss[4];
  int            m_ptr;
  bit            b_v;
  logic [VW-1:0] b_pc, b_addr;
  int            b_stride;
  logic [7:0]    b_lc;

  function automatic void model_step();
    bit acc;
    int h;
    logic [VW-1:0] dd;
    longint d;
    bit inr;
    if (!reset_n || clear) begin
      for (int i = 0; i < 4; i++) m_v[i] = 0;
      m_ptr = 0; b_v = 0; b_pc = 0; b_addr = 0; b_stride = 0; b_lc = 0;
      return;
    end
    acc = !b_v || ready;
    if (b_v && ready) b_v = 0;
    if (!commit_v) return;
    h = -1;
    for (int i = 0; i < 4; i++) if (m_v[i] && m_pc[i] == pc) h = i;
    if (h < 0) begin
      m_v[m_ptr] = 1; m_pc[m_ptr] = pc; m_last[m_ptr] = addr;
      m_stride[m_ptr] = 0; m_conf[m_ptr] = 0; m_iss[m_ptr] = 0;
      m_ptr = (m_ptr + 1) % 4;
      return;
    end
    dd  = addr - m_last[h];
    d   = longint'($signed(dd));
    inr = (d >= -128) && (d <= 127);
    if (inr && d == longint'(m_stride[h]) && d != 0) begin
      m_conf[h] = (m_conf[h] + 1 > 3) ? 3 : m_conf[h] + 1;
    end else begin
      m_stride[h] = inr ? int'(d) : 0;
      m_conf[h] = 0;
      m_iss[h] = 0;
    end
    m_last[h] = addr;
    if (m_conf[h] >= 2 && !m_iss[h] && m_stride[h] > 0 && lc != 0 && acc) begin
      b_v = 1; b_pc = pc; b_addr = addr; b_stride = m_stride[h]; b_lc = lc;
      m_iss[h] = 1;
    end
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(bit cv, logic [VW-1:0] p, logic [VW-1:0] a, logic [7:0] l, bit r, bit c = 0);
    commit_v = cv; pc = p; addr = a; lc = l; ready = r; clear = c;
    @(posedge clk);
    model_step();
    #1;
    chk("model_v", 64'(v), 64'(b_v));
    if (b_v) begin
      chk("model_pc", 64'(pco), 64'(b_pc));
      chk("model_addr", 64'(ea), 64'(b_addr));
      chk("model_stride", 64'(st), 64'(8'(b_stride)));
      chk("model_lc", 64'(lco), 64'(b_lc));
    end
  endtask

  task automatic hc(string name, bit ev, logic [VW-1:0] eaddr);
    chk({name, "_v"}, 64'(v), 64'(ev));
    if (ev) chk({name, "_addr"}, 64'(ea), 64'(eaddr));
  endtask

  typedef struct {
    logic [VW-1:0] a;
    bit            ev;
    logic [7:0]    es;
  } vec_t;

  vec_t vecs[9];
  logic [VW-1:0] pool_pc[6];
  logic [VW-1:0] gen_addr[6];
  int            gen_stride[6];
  int            stride_menu[7];

  initial begin
    vecs[0] = '{39'h8000, 0, 8'h00};
    vecs[1] = '{39'h8040, 0, 8'h00};
    vecs[2] = '{39'h8080, 0, 8'h00};
    vecs[3] = '{39'h80C0, 1, 8'h40};
    vecs[4] = '{39'h8100, 0, 8'h00};
    vecs[5] = '{39'h8200, 0, 8'h00};
    vecs[6] = '{39'h8210, 0, 8'h00};
    vecs[7] = '{39'h8220, 0, 8'h00};
    vecs[8] = '{39'h8230, 1, 8'h10};
    stride_menu = '{16, -8, 127, 128, 3, 0, 64};

    reset_n = 0; clear = 0; commit_v = 0; ready = 0; pc = 0; addr = 0; lc = 0;
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    reset_n = 1;
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 0, 1);
      chk("idle_v", 64'(v), 0);
      chk("idle_pc", 64'(pco), 0);
      chk("idle_addr", 64'(ea), 0);
      chk("idle_stride", 64'(st), 0);
      chk("idle_lc", 64'(lco), 0);
    end

    // stride confirm then break/relearn
    for (int i = 0; i < 9; i++) begin
      tick(1, 39'h1000, vecs[i].a, 8'd16, 1);
      chk("vec_v", 64'(v), 64'(vecs[i].ev));
      if (vecs[i].ev) begin
        chk("vec_pc", 64'(pco), 64'h1000);
        chk("vec_addr", 64'(ea), 64'(vecs[i].a));
        chk("vec_stride", 64'(st), 64'(vecs[i].es));
        chk("vec_lc", 64'(lco), 64'd16);
      end
    end

    // negative and out-of-range strides
    tick(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1, 39'hD000, 39'h9000 - 39'(16 * i), 8'd4, 1);
      hc("neg", 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1, 39'hE000, 39'hA000 + 39'(512 * i), 8'd4, 1);
      hc("oor", 0, 0);
    end

    // zero loop count suppresses, later nonzero count issues
    for (int i = 0; i < 4; i++) begin
      tick(1, 39'hF000, 39'(4 * i), 8'd0, 1);
      hc("lc0", 0, 0);
    end
    tick(1, 39'hF000, 39'h10, 8'd9, 1);
    hc("lc9", 1, 39'h10);

    // backpressure: A held, B dropped, B retried after drain
    tick(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1, 39'h2000, 39'h100 + 39'(8 * i), 8'd5, 0);
      hc("bp_a", i == 3, 39'h118);
    end
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 0, 0);
      hc("bp_hold", 1, 39'h118);
      chk("bp_hold_stride", 64'(st), 64'h8);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1, 39'h3000, 39'h500 + 39'(4 * i), 8'd7, 0);
      hc("bp_drop", 1, 39'h118);
    end
    tick(0, 0, 0, 0, 1);
    hc("bp_drain", 0, 0);
    tick(1, 39'h3000, 39'h510, 8'd7, 1);
    hc("bp_retry", 1, 39'h510);
    chk("bp_retry_stride", 64'(st), 64'h4);
    chk("bp_retry_lc", 64'(lco), 64'd7);
    tick(0, 0, 0, 0, 1);
    hc("bp_done", 0, 0);

    // same-cycle transfer and trigger
    tick(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1, 39'h5000, 39'(32 * i), 8'd3, 0);
      hc("tt_a", i == 3, 39'h60);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1, 39'h6000, 39'h1000 + 39'(8 * i), 8'd9, 0);
      hc("tt_hold", 1, 39'h60);
    end
    tick(1, 39'h6000, 39'h1018, 8'd9, 1);
    hc("tt_swap", 1, 39'h1018);
    chk("tt_swap_pc", 64'(pco), 64'h6000);
    chk("tt_swap_stride", 64'(st), 64'h8);
    tick(0, 0, 0, 0, 1);
    hc("tt_done", 0, 0);

    // reset mid-handshake
    tick(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(1, 39'h2000, 39'h100 + 39'(8 * i), 8'd5, 0);
    hc("rst_pre", 1, 39'h118);
    reset_n = 0;
    tick(0, 0, 0, 0, 0);
    reset_n = 1;
    hc("rst_v", 0, 0);
    chk("rst_addr", 64'(ea), 0);
    chk("rst_stride", 64'(st), 0);
    tick(0, 0, 0, 0, 1);
    hc("rst_after", 0, 0);

    // replacement: fifth PC evicts slot 0
    tick(0, 0, 0, 0, 1, 1);
    tick(1, 39'hC000, 39'h100, 8'd2, 1);
    tick(1, 39'hC000, 39'h110, 8'd2, 1);
    tick(1, 39'hC000, 39'h120, 8'd2, 1);
    tick(1, 39'hC100, 39'h0, 8'd2, 1);
    tick(1, 39'hC200, 39'h200, 8'd2, 1);
    tick(1, 39'hC300, 39'h0, 8'd2, 1);
    tick(1, 39'hC400, 39'h0, 8'd2, 1);
    hc("evict_pre", 0, 0);
    tick(1, 39'hC000, 39'h130, 8'd2, 1);
    hc("evict", 0, 0);
    for (int i = 1; i <= 3; i++) begin
      tick(1, 39'hC200, 39'h200 + 39'(16 * i), 8'd2, 1);
      hc("kept", i == 3, 39'h230);
    end

    // clear mid-training; same-cycle commit is dropped
    tick(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) tick(1, 39'h7000, 39'(64 * i), 8'd4, 1);
    tick(1, 39'h7000, 39'hC0, 8'd4, 1, 1);
    hc("clr_drop", 0, 0);
    for (int i = 4; i <= 7; i++) begin
      tick(1, 39'h7000, 39'(64 * i), 8'd4, 1);
      hc("clr_relearn", i == 7, 39'h1C0);
    end

    // random traffic against the model
    tick(0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 6; k++) begin
      pool_pc[k]    = 39'h10000 + 39'(k * 64);
      gen_addr[k]   = 39'h100000 * 39'(k + 1);
      gen_stride[k] = stride_menu[$urandom_range(0, 6)];
    end
    for (int n = 0; n < 3000; n++) begin
      int k;
      k = $urandom_range(0, 5);
      if ($urandom_range(0, 99) < 5) gen_stride[k] = stride_menu[$urandom_range(0, 6)];
      if ($urandom_range(0, 99) < 85) gen_addr[k] = gen_addr[k] + VW'(gen_stride[k]);
      else gen_addr[k] = VW'({$urandom(), $urandom()});
      reset_n = ($urandom_range(0, 199) != 0);
      tick($urandom_range(0, 99) < 70, pool_pc[k], gen_addr[k],
           ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
           $urandom_range(0, 99) < 70, $urandom_range(0, 99) == 0);
    end
    reset_n = 1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
